alu_op_sequencer: RTL and testbench

- Sequencing stage that drives the parameterized combinational ALU and consumes its 2N-bit result.
- Accepts an operation request, then issues the operation to the ALU for a programmable number of iterations.
- Registers each result and can feed the low N bits back as operand B, giving accumulate, repeated-add multiply and similar multi-step operations.
- Sits between the switch/control front-end and the ALU; its result register feeds the display stage.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_iter_counter.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU operation sequencer.
//   alu_func_t  : function codes the external ALU understands
//                 (codes 4-7 are legal on the bus and make the ALU output 0)
//   seq_state_t : sequencer FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_OR  = 3'd1,
        ALU_AND = 3'd2,
        ALU_CAT = 3'd3
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_iter_counter.sv
// ---------------------------------------------------------------------------
// alu_iter_counter
// Loadable down-counter that tracks how many ALU iterations remain.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears the count
//   load       : load load_value into the counter
//   load_value : iteration count for a new request
//   dec        : decrement by one (ignored while load is high)
//   terminal   : remaining == 1, so the current iteration is the last one
//   load_zero  : load_value == 0, evaluated combinationally on the load cycle
// ---------------------------------------------------------------------------
module alu_iter_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          terminal,
    output logic          load_zero
);

    logic [CW-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (dec) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign terminal  = (remaining == CW'(1));
    assign load_zero = (load_value == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Issues one accepted operation to the external combinational ALU for a
// programmable number of iterations and registers each 2N-bit result. In
// accumulate mode every iteration after the first takes operand B from the
// low N bits of the previous result.
// Ports:
//   Clock, Reset_b : rising-edge clock, asynchronous active-low reset
//   start          : request strobe, only looked at in IDLE
//   op_a, op_b     : operand A and initial operand B of the request
//   func           : ALU function code, passed through unchecked
//   acc_mode       : 1 = feed result[N-1:0] back as B after the first pass
//   count          : number of iterations, 0 allowed (completes immediately)
//   ALUout         : combinational result from the ALU
//   A, B, Function : operands and function code driven to the ALU
//   result         : registered ALU result
//   busy           : high from acceptance through the DONE cycle
//   done           : one-cycle completion pulse (coincides with DONE)
//   state          : current FSM state, for observation
//
// Handshake: a request is taken on a rising edge where state is IDLE and
// start is 1; busy rises on that edge and stays high until DONE ends, and
// start is ignored the whole time busy is high (no queueing).
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic            Clock,
    input  logic            Reset_b,
    input  logic            start,
    input  logic [N-1:0]    op_a,
    input  logic [N-1:0]    op_b,
    input  logic [2:0]      func,
    input  logic            acc_mode,
    input  logic [CW-1:0]   count,
    input  logic [2*N-1:0]  ALUout,
    output logic [N-1:0]    A,
    output logic [N-1:0]    B,
    output logic [2:0]      Function,
    output logic [2*N-1:0]  result,
    output logic            busy,
    output logic            done,
    output seq_state_t      state
);

    logic [N-1:0] op_b_r;
    logic         acc_r;
    logic         first;
    logic         accept;
    logic         terminal;
    logic         load_zero;

    assign accept = (state == IDLE) && start;

    alu_iter_counter #(
        .CW (CW)
    ) u_counter (
        .clk        (Clock),
        .rst_n      (Reset_b),
        .load       (accept),
        .load_value (count),
        .dec        (state == EXEC),
        .terminal   (terminal),
        .load_zero  (load_zero)
    );

    // Feedback mux: the first iteration always uses the latched operand B;
    // later ones use the truncated result only in accumulate mode, so the
    // fed-back operand wraps modulo 2^N.
    assign B = (first || !acc_r) ? op_b_r : result[N-1:0];

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state    <= IDLE;
            A        <= '0;
            op_b_r   <= '0;
            acc_r    <= 1'b0;
            Function <= '0;
            result   <= '0;
            first    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        A        <= op_a;
                        op_b_r   <= op_b;
                        Function <= func;
                        acc_r    <= acc_mode;
                        first    <= 1'b1;
                        busy     <= 1'b1;
                        // A zero-count request completes without touching result.
                        if (load_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    result <= ALUout;
                    first  <= 1'b0;
                    if (terminal) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. A small behavioural ALU closes the
// loop; all expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            Clock;
    logic            Reset_b;
    logic            start;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [2:0]      func;
    logic            acc_mode;
    logic [CW-1:0]   count;
    logic [2*N-1:0]  ALUout;
    logic [N-1:0]    A;
    logic [N-1:0]    B;
    logic [2:0]      Function;
    logic [2*N-1:0]  result;
    logic            busy;
    logic            done;
    seq_state_t      state;

    int tests;
    int fails;

    alu_op_sequencer #(.N(N), .CW(CW)) dut (
        .Clock    (Clock),
        .Reset_b  (Reset_b),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .func     (func),
        .acc_mode (acc_mode),
        .count    (count),
        .ALUout   (ALUout),
        .A        (A),
        .B        (B),
        .Function (Function),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    // Behavioural model of the external ALU.
    always_comb begin
        ALUout = '0;
        case (Function)
            3'd0:    ALUout = {4'b0000, A} + {4'b0000, B};
            3'd1:    ALUout = {7'b0, |{A, B}};
            3'd2:    ALUout = {7'b0, &{A, B}};
            3'd3:    ALUout = {A, B};
            default: ALUout = '0;
        endcase
    end

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- driver ----------------
    // Present a request on a negedge; it is accepted on the next posedge.
    // Returns 1 ns after the accepting edge with start already low.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f, input logic acc,
                         input logic [3:0] cnt);
        @(negedge Clock);
        op_a     = a;
        op_b     = b;
        func     = f;
        acc_mode = acc;
        count    = cnt;
        start    = 1'b1;
        @(posedge Clock);
        #1;
        start    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        Reset_b = 1'b0;
        start = 1'b0; op_a = '0; op_b = '0; func = '0; acc_mode = 1'b0; count = '0;
        repeat (2) @(negedge Clock);
        tests++;
        if (state !== IDLE || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 ||
            A !== 4'h0 || B !== 4'h0 || Function !== 3'd0) begin
            fails++;
            $display("FAIL reset: state=%0d busy=%b done=%b result=%h A=%h B=%h F=%0d, required all zero",
                     state, busy, done, result, A, B, Function);
        end
        @(negedge Clock);
        Reset_b = 1'b1;
    endtask

    task automatic test_single_add;
        issue(4'd3, 4'd2, 3'd0, 1'b0, 4'd1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL add_busy: busy=%b required 1", busy);
        end
        @(negedge Clock);
        tests++;
        if (done !== 1'b0 || state !== EXEC) begin
            fails++;
            $display("FAIL add_exec: done=%b state=%0d required done=0 state=EXEC", done, state);
        end
        @(negedge Clock);
        tests++;
        if (result !== 8'h05 || done !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL add_result: result=%h done=%b busy=%b required 05 1 1", result, done, busy);
        end
        @(negedge Clock);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h05) begin
            fails++;
            $display("FAIL add_after: done=%b busy=%b result=%h required 0 0 05", done, busy, result);
        end
    endtask

    // Shared shape for accumulate-style runs: checks B before each
    // iteration and result/done after each.
    task automatic test_accumulate;
        logic [7:0] exp_r [4];
        exp_r = '{8'h03, 8'h06, 8'h09, 8'h0C};
        issue(4'd3, 4'd0, 3'd0, 1'b1, 4'd4);
        @(negedge Clock);
        tests++;
        if (B !== 4'h0) begin
            fails++;
            $display("FAIL acc_b0: B=%h required 0", B);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            tests++;
            if (result !== exp_r[k-1] || done !== (k == 4)) begin
                fails++;
                $display("FAIL acc_iter%0d: result=%h done=%b required %h %b",
                         k, result, done, exp_r[k-1], (k == 4));
            end
            if (k < 4) begin
                tests++;
                if (B !== exp_r[k-1][3:0]) begin
                    fails++;
                    $display("FAIL acc_b%0d: B=%h required %h", k, B, exp_r[k-1][3:0]);
                end
            end
        end
        @(negedge Clock);
    endtask

    task automatic test_truncation;
        logic [7:0] exp_r [3];
        exp_r = '{8'h0F, 8'h1E, 8'h1D};
        issue(4'd15, 4'd0, 3'd0, 1'b1, 4'd3);
        @(negedge Clock);
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock);
            tests++;
            if (result !== exp_r[k-1] || done !== (k == 3)) begin
                fails++;
                $display("FAIL trunc_iter%0d: result=%h done=%b required %h %b",
                         k, result, done, exp_r[k-1], (k == 3));
            end
            if (k == 2) begin
                tests++;
                if (B !== 4'hE) begin
                    fails++;
                    $display("FAIL trunc_b3: B=%h required e", B);
                end
            end
        end
        @(negedge Clock);
    endtask

    task automatic test_concat;
        issue(4'hA, 4'h5, 3'd3, 1'b0, 4'd1);
        @(negedge Clock);
        tests++;
        if (Function !== 3'd3) begin
            fails++;
            $display("FAIL cat_func: Function=%0d required 3", Function);
        end
        @(negedge Clock);
        tests++;
        if (result !== 8'hA5 || done !== 1'b1) begin
            fails++;
            $display("FAIL cat_result: result=%h done=%b required a5 1", result, done);
        end
        @(negedge Clock);
        issue(4'hA, 4'h5, 3'd5, 1'b0, 4'd1);
        repeat (2) @(negedge Clock);
        tests++;
        if (result !== 8'h00 || Function !== 3'd5 || done !== 1'b1) begin
            fails++;
            $display("FAIL unused_code: result=%h F=%0d done=%b required 00 5 1", result, Function, done);
        end
        @(negedge Clock);
        issue(4'hA, 4'h5, 3'd3, 1'b0, 4'd1);
        repeat (3) @(negedge Clock);
    endtask

    task automatic test_count_zero;
        issue(4'd1, 4'd2, 3'd0, 1'b0, 4'd0);
        @(negedge Clock);
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || result !== 8'hA5) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b result=%h required 1 1 a5", done, busy, result);
        end
        // Second request while busy must be ignored.
        op_a = 4'd7; op_b = 4'd1; func = 3'd0; count = 4'd1; start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        @(negedge Clock);
        tests++;
        if (state !== IDLE || busy !== 1'b0 || done !== 1'b0 || result !== 8'hA5) begin
            fails++;
            $display("FAIL zero_ignore: state=%0d busy=%b done=%b result=%h required IDLE 0 0 a5",
                     state, busy, done, result);
        end
        @(negedge Clock);
        tests++;
        if (busy !== 1'b0 || result !== 8'hA5 || A !== 4'd1) begin
            fails++;
            $display("FAIL zero_hold: busy=%b result=%h A=%h required 0 a5 1", busy, result, A);
        end
    endtask

    task automatic test_reset_mid_exec;
        int saw_done;
        saw_done = 0;
        issue(4'd1, 4'd2, 3'd3, 1'b1, 4'd4);
        @(negedge Clock);
        @(negedge Clock);
        tests++;
        if (result !== 8'h12 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: result=%h busy=%b required 12 1", result, busy);
        end
        #1;
        Reset_b = 1'b0;
        #1;
        tests++;
        if (state !== IDLE || A !== 4'h0 || B !== 4'h0 || Function !== 3'd0 ||
            result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: state=%0d A=%h B=%h F=%0d result=%h busy=%b done=%b required all zero",
                     state, A, B, Function, result, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            if (done === 1'b1) saw_done = 1;
        end
        Reset_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            if (done === 1'b1) saw_done = 1;
        end
        tests++;
        if (saw_done != 0 || state !== IDLE) begin
            fails++;
            $display("FAIL mid_no_done: saw_done=%0d state=%0d required 0 IDLE", saw_done, state);
        end
        issue(4'd2, 4'd3, 3'd0, 1'b0, 4'd1);
        repeat (2) @(negedge Clock);
        tests++;
        if (result !== 8'h05 || done !== 1'b1) begin
            fails++;
            $display("FAIL mid_recover: result=%h done=%b required 05 1", result, done);
        end
        @(negedge Clock);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_add();
        test_accumulate();
        test_truncation();
        test_concat();
        test_count_zero();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
